id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Pipeline register and operand-select stage that sits directly upstream of the ALU in the 16-bit MIPS-style datapath. It captures decoded operands and control from the decode stage and presents them to the ALU as `srcA`, `srcB` and `alucontrol`. It resolves data hazards by forwarding results from the EX/MEM and MEM/WB stages. It also detects load-use hazards, requesting a decode stall and inserting a bubble.

## Interface
Parameters:
- `n`, 16, datapath width; must match the ALU.
- `r`, 3, register-index width (2^r architectural registers; register 0 reads as zero and is never forwarded).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `id_valid`  in  1  decode slot holds a real instruction.
- `id_rd1`, `id_rd2`  in  n  register-file read data for rs, rt.
- `id_imm`  in  n  sign-extended immediate.
- `id_rs`, `id_rt`, `id_rd`  in  r  register indices.
- `id_uses_rt`  in  1  instruction reads rt as a source (R-type, store, branch).
- `id_alucontrol`  in  3  ALU opcode, passed through unchanged.
- `id_alusrc`, `id_regdst`, `id_regwrite`, `id_memwrite`, `id_memtoreg`  in  1 each  decoded control.
- `stall`  in  1  downstream hold request; freezes this stage.
- `flush`  in  1  squash the instruction entering this stage (taken branch/jump).
- `exm_regwrite`  in  1, `exm_wreg`  in  r, `exm_result`  in  n  EX/MEM forwarding source.
- `mwb_regwrite`  in  1, `mwb_wreg`  in  r, `mwb_result`  in  n  MEM/WB forwarding source.
- `srcA`, `srcB`  out  n  ALU operands.
- `alucontrol`  out  3  ALU opcode.
- `writedata`  out  n  forwarded rt value for stores.
- `write_reg`  out  r  destination index.
- `ex_valid`, `ex_regwrite`, `ex_memwrite`, `ex_memtoreg`  out  1 each  registered control.
- `load_use_stall`  out  1  combinational; tells PC/IF-ID to hold.

## Operation
- State: registered copies of every `id_*` input except `id_uses_rt`.
- Next-state priority at each rising edge:
  1. `reset`: all fields become 0.
  2. `flush`: load a bubble. A bubble is all fields 0, with `valid`, `regwrite` and `memwrite` equal to 0.
  3. `stall`: hold all fields.
  4. `load_use_stall`: load a bubble.
  5. Otherwise, load the `id_*` inputs.
- `load_use_stall` = `ex_valid & ex_memtoreg & ex_regwrite & (wreg != 0) & ((wreg == id_rs) | (id_uses_rt & wreg == id_rt)) & id_valid`. It is gated off when `flush` is high.
- `write_reg` = `regdst ? rd : rt`, taken from the registered fields.
- Forwarding is applied separately to rs and to rt, using register index x and stored data d:
  - Select `exm_result` if `exm_regwrite & exm_wreg == x & x != 0`.
  - Else select `mwb_result` if `mwb_regwrite & mwb_wreg == x & x != 0`.
  - Else select d.
  - EX/MEM always wins over MEM/WB.
- `srcA` = forwarded rs.
- `writedata` = forwarded rt.
- `srcB` = `alusrc ? imm : forwarded rt`.
- A bubble presents `srcA`, `srcB`, `alucontrol` and `write_reg` all equal to 0. The ALU computes a harmless AND.

## Timing
- Latency: one cycle from `id_*` to registered outputs. Forwarding muxes are combinational from registered state and the forwarding inputs, with zero added latency.
- Reset values: all registered outputs are 0. `srcA`/`srcB`/`writedata` are 0, because reg 0 is never forwarded. `load_use_stall` is 0.
- `stall` with `flush` at the same edge: flush wins and a bubble is loaded.
- `stall` for k cycles holds the same instruction. Forwarded operands may change during the hold as the downstream forwarding inputs change.
- A load-use pair costs exactly one bubble. On the next cycle the load sits in EX/MEM, `load_use_stall` drops, and the dependent instruction loads.
- A reset asserted mid-stream discards the in-flight instruction within one edge. No partial state survives.

## Test plan
- Reset: hold `reset` for 2 cycles with arbitrary inputs, then check all outputs are 0 and `ex_valid` is 0. Release with `id_valid=1`, `rd1=0x0005`, `rd2=0x0003`, `alucontrol=010`, `alusrc=0`. One cycle later, check `srcA=0x0005`, `srcB=0x0003`, `alucontrol=010`.
- Forward priority: stage holds rs=2, rt=3 with stored data 0x1111 and 0x2222. Drive `exm_wreg=2`, `exm_result=0xAAAA`, `mwb_wreg=2`, `mwb_result=0xBBBB` and `mwb_wreg` redirected to 3 with `mwb_result=0xCCCC`. Check `srcA=0xAAAA` and `srcB=0xCCCC`. Repeat with index 0 and check that no forwarding occurs.
- Immediate select: set `alusrc=1`, `imm=0xFFF0`, rt forwarded to 0x1234. Check `srcB=0xFFF0` and `writedata=0x1234`.
- Load-use: the load `lw r4` is in this stage while decode presents `add` with rs=4. Check `load_use_stall=1`, a bubble on the next edge with `ex_regwrite=0`, then `add` loaded one cycle later.
- Stall/flush: assert `stall` for 3 cycles and check outputs held. Assert `stall` and `flush` together and check a bubble with `ex_valid=0` and `ex_memwrite=0`.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Feeds srcA/srcB/alucontrol to the 16-bit ALU and asks decode to hold on a load-use pair.
module id_ex_stage #(
    parameter int unsigned n = 16,
    parameter int unsigned r = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         id_valid,
    input  logic [n-1:0] id_rd1,
    input  logic [n-1:0] id_rd2,
    input  logic [n-1:0] id_imm,
    input  logic [r-1:0] id_rs,
    input  logic [r-1:0] id_rt,
    input  logic [r-1:0] id_rd,
    input  logic         id_uses_rt,
    input  logic [2:0]   id_alucontrol,
    input  logic         id_alusrc,
    input  logic         id_regdst,
    input  logic         id_regwrite,
    input  logic         id_memwrite,
    input  logic         id_memtoreg,
    input  logic         stall,
    input  logic         flush,
    input  logic         exm_regwrite,
    input  logic [r-1:0] exm_wreg,
    input  logic [n-1:0] exm_result,
    input  logic         mwb_regwrite,
    input  logic [r-1:0] mwb_wreg,
    input  logic [n-1:0] mwb_result,
    output logic [n-1:0] srcA,
    output logic [n-1:0] srcB,
    output logic [2:0]   alucontrol,
    output logic [n-1:0] writedata,
    output logic [r-1:0] write_reg,
    output logic         ex_valid,
    output logic         ex_regwrite,
    output logic         ex_memwrite,
    output logic         ex_memtoreg,
    output logic         load_use_stall
);

    logic         r_valid;
    logic [n-1:0] r_rd1;
    logic [n-1:0] r_rd2;
    logic [n-1:0] r_imm;
    logic [r-1:0] r_rs;
    logic [r-1:0] r_rt;
    logic [r-1:0] r_rd;
    logic [2:0]   r_alucontrol;
    logic         r_alusrc;
    logic         r_regdst;
    logic         r_regwrite;
    logic         r_memwrite;
    logic         r_memtoreg;

    logic         w_bubble;
    logic         w_load;
    logic         w_rs_hit;
    logic         w_rt_hit;
    logic [r-1:0] w_wreg;
    logic [n-1:0] w_fwd_a;
    logic [n-1:0] w_fwd_b;

    assign w_wreg = r_regdst ? r_rd : r_rt;

    // Hazard against the load currently held here; a flush makes it moot.
    always_comb begin
        w_rs_hit       = (w_wreg == id_rs);
        w_rt_hit       = id_uses_rt && (w_wreg == id_rt);
        load_use_stall = r_valid && r_memtoreg && r_regwrite && (w_wreg != '0) &&
                         (w_rs_hit || w_rt_hit) && id_valid && !flush;
    end

    always_comb begin
        w_bubble = 1'b0;
        w_load   = 1'b0;
        if (flush) begin
            w_bubble = 1'b1;
        end else if (stall) begin
            w_bubble = 1'b0;
        end else if (load_use_stall) begin
            w_bubble = 1'b1;
        end else begin
            w_load = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_bubble) begin
            r_valid      <= 1'b0;
            r_rd1        <= '0;
            r_rd2        <= '0;
            r_imm        <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_alucontrol <= '0;
            r_alusrc     <= 1'b0;
            r_regdst     <= 1'b0;
            r_regwrite   <= 1'b0;
            r_memwrite   <= 1'b0;
            r_memtoreg   <= 1'b0;
        end else if (w_load) begin
            r_valid      <= id_valid;
            r_rd1        <= id_rd1;
            r_rd2        <= id_rd2;
            r_imm        <= id_imm;
            r_rs         <= id_rs;
            r_rt         <= id_rt;
            r_rd         <= id_rd;
            r_alucontrol <= id_alucontrol;
            r_alusrc     <= id_alusrc;
            r_regdst     <= id_regdst;
            r_regwrite   <= id_regwrite;
            r_memwrite   <= id_memwrite;
            r_memtoreg   <= id_memtoreg;
        end
    end

    // EX/MEM is the younger result, so it takes precedence; register 0 is never forwarded.
    always_comb begin
        w_fwd_a = r_rd1;
        if (exm_regwrite && (exm_wreg == r_rs) && (r_rs != '0)) begin
            w_fwd_a = exm_result;
        end else if (mwb_regwrite && (mwb_wreg == r_rs) && (r_rs != '0)) begin
            w_fwd_a = mwb_result;
        end
    end

    always_comb begin
        w_fwd_b = r_rd2;
        if (exm_regwrite && (exm_wreg == r_rt) && (r_rt != '0)) begin
            w_fwd_b = exm_result;
        end else if (mwb_regwrite && (mwb_wreg == r_rt) && (r_rt != '0)) begin
            w_fwd_b = mwb_result;
        end
    end

    assign srcA        = w_fwd_a;
    assign srcB        = r_alusrc ? r_imm : w_fwd_b;
    assign writedata   = w_fwd_b;
    assign alucontrol  = r_alucontrol;
    assign write_reg   = w_wreg;
    assign ex_valid    = r_valid;
    assign ex_regwrite = r_regwrite;
    assign ex_memwrite = r_memwrite;
    assign ex_memtoreg = r_memtoreg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic against a slot-level model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [15:0] id_rd1, id_rd2, id_imm;
    logic [2:0]  id_rs, id_rt, id_rd;
    logic        id_uses_rt;
    logic [2:0]  id_alucontrol;
    logic        id_alusrc, id_regdst, id_regwrite, id_memwrite, id_memtoreg;
    logic        stall, flush;
    logic        exm_regwrite, mwb_regwrite;
    logic [2:0]  exm_wreg, mwb_wreg;
    logic [15:0] exm_result, mwb_result;
    logic [15:0] srcA, srcB, writedata;
    logic [2:0]  alucontrol, write_reg;
    logic        ex_valid, ex_regwrite, ex_memwrite, ex_memtoreg, load_use_stall;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.n(16), .r(3)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .id_alucontrol(id_alucontrol), .id_alusrc(id_alusrc), .id_regdst(id_regdst),
        .id_regwrite(id_regwrite), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .stall(stall), .flush(flush),
        .exm_regwrite(exm_regwrite), .exm_wreg(exm_wreg), .exm_result(exm_result),
        .mwb_regwrite(mwb_regwrite), .mwb_wreg(mwb_wreg), .mwb_result(mwb_result),
        .srcA(srcA), .srcB(srcB), .alucontrol(alucontrol), .writedata(writedata),
        .write_reg(write_reg), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .load_use_stall(load_use_stall)
    );

    // Model: the instruction occupying the stage, as a plain record.
    typedef struct packed {
        logic        valid;
        logic [15:0] rd1, rd2, imm;
        logic [2:0]  rs, rt, rd, aluc;
        logic        alusrc, regdst, regwrite, memwrite, memtoreg;
    } slot_t;

    slot_t m;

    function automatic slot_t from_inputs();
        slot_t s;
        s.valid = id_valid; s.rd1 = id_rd1; s.rd2 = id_rd2; s.imm = id_imm;
        s.rs = id_rs; s.rt = id_rt; s.rd = id_rd; s.aluc = id_alucontrol;
        s.alusrc = id_alusrc; s.regdst = id_regdst; s.regwrite = id_regwrite;
        s.memwrite = id_memwrite; s.memtoreg = id_memtoreg;
        return s;
    endfunction

    // Value register idx would hold once the newest pending write lands.
    function automatic logic [15:0] value_of(logic [2:0] idx, logic [15:0] stored);
        if (idx == 0) return stored;
        if (exm_regwrite && exm_wreg == idx) return exm_result;
        if (mwb_regwrite && mwb_wreg == idx) return mwb_result;
        return stored;
    endfunction

    function automatic logic [2:0] dest(slot_t s);
        return s.regdst ? s.rd : s.rt;
    endfunction

    function automatic logic exp_lus();
        logic [2:0] w;
        logic reads;
        w = dest(m);
        reads = (id_rs == w) || (id_uses_rt && id_rt == w);
        return !flush && id_valid && m.valid && m.memtoreg && m.regwrite && w != 0 && reads;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("srcA", srcA, value_of(m.rs, m.rd1));
        chk("srcB", srcB, m.alusrc ? m.imm : value_of(m.rt, m.rd2));
        chk("writedata", writedata, value_of(m.rt, m.rd2));
        chk("alucontrol", {13'd0, alucontrol}, {13'd0, m.aluc});
        chk("write_reg", {13'd0, write_reg}, {13'd0, dest(m)});
        chk("ex_valid", {15'd0, ex_valid}, {15'd0, m.valid});
        chk("ex_regwrite", {15'd0, ex_regwrite}, {15'd0, m.regwrite});
        chk("ex_memwrite", {15'd0, ex_memwrite}, {15'd0, m.memwrite});
        chk("ex_memtoreg", {15'd0, ex_memtoreg}, {15'd0, m.memtoreg});
        chk("load_use_stall", {15'd0, load_use_stall}, {15'd0, exp_lus()});
    endtask

    // Check at negedge, then advance one edge applying the stage's priority rules.
    task automatic step();
        logic lus;
        @(negedge clk);
        check_all();
        lus = exp_lus();
        @(posedge clk);
        if (reset || flush) m = '0;
        else if (stall) m = m;
        else if (lus) m = '0;
        else m = from_inputs();
        #1;
    endtask

    task automatic rand_id();
        id_valid = ($urandom_range(0, 7) != 0);
        id_rd1 = 16'($urandom); id_rd2 = 16'($urandom); id_imm = 16'($urandom);
        id_rs = 3'($urandom); id_rt = 3'($urandom); id_rd = 3'($urandom);
        id_uses_rt = 1'($urandom); id_alucontrol = 3'($urandom);
        id_alusrc = 1'($urandom); id_regdst = 1'($urandom); id_regwrite = 1'($urandom);
        id_memwrite = 1'($urandom); id_memtoreg = ($urandom_range(0, 2) == 0);
    endtask

    task automatic rand_fwd();
        exm_regwrite = 1'($urandom); exm_wreg = 3'($urandom); exm_result = 16'($urandom);
        mwb_regwrite = 1'($urandom); mwb_wreg = 3'($urandom); mwb_result = 16'($urandom);
    endtask

    task automatic set_instr(input logic [2:0] rs, input logic [2:0] rt, input logic [15:0] d1,
                             input logic [15:0] d2);
        id_valid = 1; id_rs = rs; id_rt = rt; id_rd = 3'd0; id_rd1 = d1; id_rd2 = d2;
        id_imm = 16'h0; id_uses_rt = 1; id_alucontrol = 3'b010; id_alusrc = 0;
        id_regdst = 0; id_regwrite = 0; id_memwrite = 0; id_memtoreg = 0;
    endtask

    initial begin
        // Reset held for two edges with arbitrary inputs.
        reset = 1; stall = 0; flush = 0;
        rand_id(); rand_fwd();
        @(posedge clk); m = '0; #1;
        step();
        chk("rst_srcA", srcA, 16'h0);
        chk("rst_srcB", srcB, 16'h0);
        chk("rst_writedata", writedata, 16'h0);
        chk("rst_ex_valid", {15'd0, ex_valid}, 16'h0);
        chk("rst_lus", {15'd0, load_use_stall}, 16'h0);

        reset = 0; exm_regwrite = 0; mwb_regwrite = 0;
        set_instr(3'd1, 3'd2, 16'h0005, 16'h0003);
        step();
        chk("rel_srcA", srcA, 16'h0005);
        chk("rel_srcB", srcB, 16'h0003);
        chk("rel_aluc", {13'd0, alucontrol}, 16'h0002);

        // Forward priority: EX/MEM beats MEM/WB on rs; MEM/WB alone supplies rt.
        set_instr(3'd2, 3'd3, 16'h1111, 16'h2222);
        step();
        stall = 1;
        exm_regwrite = 1; exm_wreg = 3'd2; exm_result = 16'hAAAA;
        mwb_regwrite = 1; mwb_wreg = 3'd2; mwb_result = 16'hBBBB;
        #1;
        chk("fwd_both_srcA", srcA, 16'hAAAA);
        chk("fwd_both_srcB", srcB, 16'h2222);
        mwb_wreg = 3'd3; mwb_result = 16'hCCCC;
        #1;
        chk("fwd_srcA", srcA, 16'hAAAA);
        chk("fwd_srcB", srcB, 16'hCCCC);
        step();
        stall = 0;
        set_instr(3'd0, 3'd0, 16'h1111, 16'h2222);
        exm_wreg = 3'd0; mwb_wreg = 3'd0;
        step();
        chk("r0_srcA", srcA, 16'h1111);
        chk("r0_srcB", srcB, 16'h2222);

        // Immediate select still forwards rt onto writedata.
        set_instr(3'd1, 3'd3, 16'h0001, 16'h0002);
        id_alusrc = 1; id_imm = 16'hFFF0; id_memwrite = 1;
        exm_wreg = 3'd3; exm_result = 16'h1234; mwb_regwrite = 0;
        step();
        chk("imm_srcB", srcB, 16'hFFF0);
        chk("imm_writedata", writedata, 16'h1234);

        // Load-use: lw r4 here, add with rs=4 in decode.
        exm_regwrite = 0; mwb_regwrite = 0;
        set_instr(3'd1, 3'd4, 16'h0010, 16'h0000);
        id_alusrc = 1; id_regwrite = 1; id_memtoreg = 1; id_uses_rt = 0;
        step();
        set_instr(3'd4, 3'd5, 16'h0000, 16'h0000);
        id_rd = 3'd6; id_regdst = 1; id_regwrite = 1;
        #1;
        chk("lu_stall", {15'd0, load_use_stall}, 16'h1);
        step();
        chk("lu_bubble_regwrite", {15'd0, ex_regwrite}, 16'h0);
        chk("lu_bubble_valid", {15'd0, ex_valid}, 16'h0);
        chk("lu_drop", {15'd0, load_use_stall}, 16'h0);
        step();
        chk("lu_add_valid", {15'd0, ex_valid}, 16'h1);
        chk("lu_add_wreg", {13'd0, write_reg}, 16'h0006);

        // Stall holds for three cycles, then stall+flush loads a bubble.
        set_instr(3'd1, 3'd2, 16'h0BAD, 16'h0C0D);
        id_alucontrol = 3'd3; id_memwrite = 1;
        step();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            rand_id();
            step();
            chk("hold_srcA", srcA, 16'h0BAD);
            chk("hold_srcB", srcB, 16'h0C0D);
            chk("hold_memwrite", {15'd0, ex_memwrite}, 16'h1);
            chk("hold_aluc", {13'd0, alucontrol}, 16'h0003);
        end
        flush = 1;
        step();
        chk("sf_valid", {15'd0, ex_valid}, 16'h0);
        chk("sf_memwrite", {15'd0, ex_memwrite}, 16'h0);
        chk("sf_srcA", srcA, 16'h0);
        flush = 0; stall = 0;

        // Randomized traffic checked every cycle by step().
        for (int i = 0; i < 400; i++) begin
            rand_id(); rand_fwd();
            reset = ($urandom_range(0, 31) == 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 5) == 0);
            step();
        end
        reset = 0; flush = 0; stall = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
